// File: rtl/apb_slave_regbank_if.sv
// APB completer-side bus bundle: one-hot bank select, access strobe, address/data and response.
// The master modport drives requests; the slave modport drives the response.
interface apb_slave_regbank_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_SLAVES = 3
);
    logic [NUM_SLAVES-1:0]   Pselx;
    logic                    Penable;
    logic                    Pwrite;
    logic [ADDR_WIDTH-1:0]   Paddr;
    logic [DATA_WIDTH-1:0]   Pwdata;
    logic [DATA_WIDTH/8-1:0] Pstrb;
    logic [DATA_WIDTH-1:0]   Prdata;
    logic                    Pready;
    logic                    Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB completer array: NUM_SLAVES independent register banks behind a one-hot select, with
// byte-strobed writes, programmable wait states and an error response for bad accesses.
module apb_slave_regbank #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned NUM_SLAVES     = 3,
    parameter int unsigned REGS_PER_SLAVE = 16,
    parameter int unsigned WAIT_STATES    = 0
) (
    input logic                Pclk,
    input logic                Preset,
    apb_slave_regbank_if.slave apb
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned IdxW  = $clog2(REGS_PER_SLAVE);
    localparam int unsigned SelW  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned WordW = ADDR_WIDTH - 2;

    typedef enum logic {
        StIdle,
        StAccess
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] bank_q [NUM_SLAVES][REGS_PER_SLAVE];
    logic [DATA_WIDTH-1:0] bank_d [NUM_SLAVES][REGS_PER_SLAVE];

    logic                  sel;
    logic                  multi;
    logic                  out_of_range;
    logic                  err;
    logic                  ready;
    logic [SelW-1:0]       sel_idx;
    logic [WordW-1:0]      word_full;
    logic [IdxW-1:0]       word_idx;
    logic [DATA_WIDTH-1:0] rdata;

    assign sel          = |apb.Pselx;
    assign multi        = (apb.Pselx & (apb.Pselx - NUM_SLAVES'(1))) != '0;
    assign word_full    = apb.Paddr[ADDR_WIDTH-1:2];
    assign word_idx     = word_full[IdxW-1:0];
    assign out_of_range = (word_full >> IdxW) != '0;
    assign err          = multi | (apb.Paddr[1:0] != 2'b00) | out_of_range;

    // Lowest set select bit; only meaningful when the select is one-hot (otherwise err is set).
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (apb.Pselx[i]) begin
                sel_idx = SelW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ready      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Penable without a preceding setup phase is ignored.
                if (sel && !apb.Penable) begin
                    state_d    = StAccess;
                    wait_cnt_d = 4'(WAIT_STATES);
                end
            end
            StAccess: begin
                if (!sel) begin
                    state_d = StIdle;
                end else if (!apb.Penable) begin
                    wait_cnt_d = 4'(WAIT_STATES);
                end else if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    // A reset on this edge kills the transfer, so no completion is signalled.
                    ready   = !Preset;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bank_d = bank_q;
        rdata  = '0;
        if (ready && !err) begin
            if (apb.Pwrite) begin
                for (int b = 0; b < StrbW; b++) begin
                    if (apb.Pstrb[b]) begin
                        bank_d[sel_idx][word_idx][b*8 +: 8] = apb.Pwdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata = bank_q[sel_idx][word_idx];
            end
        end
    end

    assign apb.Pready  = ready;
    assign apb.Pslverr = ready & err;
    assign apb.Prdata  = rdata;

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            for (int s = 0; s < NUM_SLAVES; s++) begin
                for (int r = 0; r < REGS_PER_SLAVE; r++) begin
                    bank_q[s][r] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bank_q     <= bank_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: a zero-wait and a three-wait instance share one stimulus bus,
// checked by a directed vector table, hand-written corner sequences and a random array model.
module tb_apb_slave_regbank;

    logic        clk;
    logic        rst;
    bit          tgt;  // 0 drives the zero-wait instance, 1 the three-wait instance
    logic [2:0]  psel;
    logic        pen;
    logic        pwr;
    logic [31:0] padr;
    logic [31:0] pwd;
    logic [3:0]  pst;
    logic        rdy;
    logic        slverr;
    logic [31:0] prdata;

    int n_checks = 0;
    int n_errors = 0;

    apb_slave_regbank_if bus0 ();
    apb_slave_regbank_if bus3 ();

    apb_slave_regbank #(.WAIT_STATES(0)) dut0 (.Pclk(clk), .Preset(rst), .apb(bus0));
    apb_slave_regbank #(.WAIT_STATES(3)) dut3 (.Pclk(clk), .Preset(rst), .apb(bus3));

    assign bus0.Pselx   = tgt ? 3'b000 : psel;
    assign bus3.Pselx   = tgt ? psel : 3'b000;
    assign bus0.Penable = pen;
    assign bus3.Penable = pen;
    assign bus0.Pwrite  = pwr;
    assign bus3.Pwrite  = pwr;
    assign bus0.Paddr   = padr;
    assign bus3.Paddr   = padr;
    assign bus0.Pwdata  = pwd;
    assign bus3.Pwdata  = pwd;
    assign bus0.Pstrb   = pst;
    assign bus3.Pstrb   = pst;
    assign rdy    = tgt ? bus3.Pready  : bus0.Pready;
    assign slverr = tgt ? bus3.Pslverr : bus0.Pslverr;
    assign prdata = tgt ? bus3.Prdata  : bus0.Prdata;

    always #5 clk = ~clk;

    // Reference model: mem[instance][bank][word].
    logic [31:0] mem [2][3][16];

    task automatic model_clear();
        for (int t = 0; t < 2; t++)
            for (int s = 0; s < 3; s++)
                for (int r = 0; r < 16; r++) mem[t][s][r] = 32'h0;
    endtask

    function automatic bit model_err(input logic [2:0] s, input logic [31:0] a);
        return ($countones(s) != 1) || (a[1:0] != 2'b00) || ((a >> 2) >= 32'd16);
    endfunction

    task automatic model_access(input bit t, input logic [2:0] s, input bit w,
                                input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                                output logic [31:0] exp_rd, output bit exp_er);
        int k;
        int wi;
        exp_er = model_err(s, a);
        exp_rd = 32'h0;
        k = 0;
        for (int i = 2; i >= 0; i--) if (s[i]) k = i;
        wi = int'(a >> 2);
        if (!exp_er) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) mem[t][k][wi][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                exp_rd = mem[t][k][wi];
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        psel = 3'b000;
        pen  = 1'b0;
    endtask

    // One complete transfer; lat counts access-phase cycles up to and including Pready (-1 on timeout).
    task automatic xfer(input bit t, input logic [2:0] s, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] st,
                        output logic [31:0] rd, output bit er, output int lat);
        @(negedge clk);
        tgt  = t;
        psel = s;
        pwr  = w;
        padr = a;
        pwd  = d;
        pst  = st;
        pen  = 1'b0;
        @(negedge clk);
        pen = 1'b1;
        lat = 1;
        forever begin
            #1;
            if (rdy) begin
                rd = prdata;
                er = slverr;
                break;
            end
            if (lat >= 40) begin
                rd  = 32'hxxxx_xxxx;
                er  = 1'b0;
                lat = -1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_checked(input string tag, input bit t, input logic [2:0] s, input bit w,
                               input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] rd;
        logic [31:0] erd;
        bit          er;
        bit          eer;
        int          lat;
        xfer(t, s, w, a, d, st, rd, er, lat);
        model_access(t, s, w, a, d, st, erd, eer);
        chk({tag, " rdata"}, rd, erd);
        chk({tag, " slverr"}, 32'(er), 32'(eer));
        chk({tag, " latency"}, 32'(lat), t ? 32'd4 : 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  sel;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] rd;
        logic [31:0] erd;
        bit          er;
        bit          eer;
        bit          seen;
        int          lat;

        vecs[0]  = '{"rd_b0_4",       3'b001, 1'b0, 32'h04, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[1]  = '{"wr_b1_8",       3'b010, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[2]  = '{"rd_b1_8",       3'b010, 1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{"rd_b0_8",       3'b001, 1'b0, 32'h08, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[4]  = '{"wr_b2_0",       3'b100, 1'b1, 32'h00, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[5]  = '{"wr_b2_0_strb",  3'b100, 1'b1, 32'h00, 32'h0000AB00, 4'h2, 32'h0,        1'b0};
        vecs[6]  = '{"rd_b2_0",       3'b100, 1'b0, 32'h00, 32'h0,        4'h0, 32'h1122AB44, 1'b0};
        vecs[7]  = '{"wr_oob_40",     3'b001, 1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{"rd_oob_40",     3'b001, 1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[9]  = '{"wr_misalign",   3'b010, 1'b1, 32'h0A, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[10] = '{"wr_multi",      3'b011, 1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[11] = '{"rd_b1_8_keep",  3'b010, 1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{"rd_multi",      3'b011, 1'b0, 32'h08, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[13] = '{"wr_b1_c_nostrb",3'b010, 1'b1, 32'h0C, 32'hCAFEF00D, 4'h0, 32'h0,        1'b0};
        vecs[14] = '{"rd_b1_c",       3'b010, 1'b0, 32'h0C, 32'h0,        4'h0, 32'h0,        1'b0};

        clk  = 1'b0;
        rst  = 1'b1;
        tgt  = 1'b0;
        psel = 3'b000;
        pen  = 1'b0;
        pwr  = 1'b0;
        padr = 32'h0;
        pwd  = 32'h0;
        pst  = 4'h0;
        model_clear();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset dut0 pready", 32'(bus0.Pready), 32'd0);
        chk("reset dut0 pslverr", 32'(bus0.Pslverr), 32'd0);
        chk("reset dut0 prdata", bus0.Prdata, 32'd0);
        chk("reset dut3 pready", 32'(bus3.Pready), 32'd0);
        chk("reset dut3 prdata", bus3.Prdata, 32'd0);

        // Directed table, back-to-back on the zero-wait instance.
        for (int i = 0; i < 15; i++) begin
            xfer(1'b0, vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 rd, er, lat);
            model_access(1'b0, vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                         vecs[i].strb, erd, eer);
            chk({vecs[i].name, " rdata"}, rd, vecs[i].exp_rd);
            chk({vecs[i].name, " slverr"}, 32'(er), 32'(vecs[i].exp_err));
            chk({vecs[i].name, " latency"}, 32'(lat), 32'd1);
        end
        bus_idle();

        // Penable in IDLE without setup never completes.
        @(negedge clk);
        tgt  = 1'b0;
        psel = 3'b001;
        pwr  = 1'b0;
        padr = 32'h4;
        pen  = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            #1 seen |= rdy;
            @(negedge clk);
        end
        chk("idle penable dut0 no pready", 32'(seen), 32'd0);
        psel = 3'b000;
        pen  = 1'b0;

        // Wait states: write then read back on the three-wait instance.
        run_checked("ws3 write", 1'b1, 3'b001, 1'b1, 32'h4, 32'h12345678, 4'hF);
        run_checked("ws3 read", 1'b1, 3'b001, 1'b0, 32'h4, 32'h0, 4'h0);
        bus_idle();

        // Abort mid-wait: no Pready, no write, FSM back in IDLE.
        @(negedge clk);
        tgt  = 1'b1;
        psel = 3'b010;
        pwr  = 1'b1;
        padr = 32'h10;
        pwd  = 32'hAAAA5555;
        pst  = 4'hF;
        pen  = 1'b0;
        @(negedge clk);
        pen  = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            #1 seen |= rdy;
            @(negedge clk);
        end
        psel = 3'b000;
        pen  = 1'b0;
        #1 seen |= rdy;
        chk("abort no pready", 32'(seen), 32'd0);
        @(negedge clk);
        psel = 3'b010;
        pen  = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            #1 seen |= rdy;
            @(negedge clk);
        end
        chk("after abort idle no pready", 32'(seen), 32'd0);
        psel = 3'b000;
        pen  = 1'b0;
        run_checked("abort target unchanged", 1'b1, 3'b010, 1'b0, 32'h10, 32'h0, 4'h0);
        bus_idle();

        // Reset on the would-be completing edge of a wait-state write.
        @(negedge clk);
        tgt  = 1'b1;
        psel = 3'b100;
        pwr  = 1'b1;
        padr = 32'h8;
        pwd  = 32'h55667788;
        pst  = 4'hF;
        pen  = 1'b0;
        @(negedge clk);
        pen = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset dominates pready", 32'(rdy), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        psel = 3'b000;
        pen  = 1'b0;
        model_clear();
        run_checked("post reset dut3 b2_8", 1'b1, 3'b100, 1'b0, 32'h8, 32'h0, 4'h0);
        run_checked("post reset dut0 b1_8", 1'b0, 3'b010, 1'b0, 32'h8, 32'h0, 4'h0);

        // Random traffic across both instances against the array model.
        for (int i = 0; i < 300; i++) begin
            bit          t;
            logic [2:0]  s;
            logic [31:0] a;
            t = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                s = 3'($urandom_range(0, 3));
                s = (s == 3'd0) ? 3'b011 : (s == 3'd1) ? 3'b101 : (s == 3'd2) ? 3'b110 : 3'b111;
            end else begin
                s = 3'b001 << $urandom_range(0, 2);
            end
            a = 32'($urandom_range(0, 19)) << 2;
            if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
            run_checked("random", t, s, $urandom_range(0, 1) == 1, a, $urandom,
                        4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
